// File: rtl/pulpemu_reset_seq_pkg.sv
// Shared types and helpers for the FPGA emulation reset sequencer.
package pulpemu_reset_pkg;

  localparam int RESET_COUNT_W = 8;

  typedef enum logic [1:0] {
    S_LOCK_WAIT = 2'd0,
    S_HOLD      = 2'd1,
    S_JTAG_REL  = 2'd2,
    S_RUN       = 2'd3
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR       = 2'd0,
    CAUSE_LOCK_LOSS = 2'd1,
    CAUSE_BUTTON    = 2'd2,
    CAUSE_SW        = 2'd3
  } rst_cause_e;

  function automatic logic [RESET_COUNT_W-1:0] sat_inc(input logic [RESET_COUNT_W-1:0] v);
    return (&v) ? v : v + RESET_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/pulpemu_reset_seq_debounce.sv
// Two-flop synchroniser plus debouncer: the output level follows the input only
// after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module pulpemu_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic ref_clk,
  input  logic reset,
  input  logic async_in,
  output logic level_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_out = level_q;

endmodule

// File: rtl/pulpemu_reset_seq.sv
// Reset sequencer: waits for a stable clock lock, holds both resets, releases the
// TAP reset JTAG_LEAD cycles ahead of the SoC reset, and records the last cause.
module pulpemu_reset_seq
  import pulpemu_reset_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LOCK_STABLE     = 8,
  parameter int unsigned HOLD_CYCLES     = 32,
  parameter int unsigned JTAG_LEAD       = 4
) (
  input  logic                     ref_clk,
  input  logic                     reset,
  input  logic                     pad_reset_btn,
  input  logic                     clk_locked,
  input  logic                     sw_reset_req,
  output logic                     soc_reset_n,
  output logic                     jtag_trst_n,
  output logic [1:0]               seq_state,
  output logic [1:0]               last_cause,
  output logic [RESET_COUNT_W-1:0] reset_count
);

  localparam int unsigned LOCK_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned LEAD_W = $clog2(JTAG_LEAD + 1);

  logic btn_db;
  logic lsync1_q, lsync2_q;
  logic locked_s;

  rst_state_e              state_q, state_d;
  rst_cause_e              cause_q, cause_d;
  logic [LOCK_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [LEAD_W-1:0]       lead_cnt_q, lead_cnt_d;
  logic [RESET_COUNT_W-1:0] count_q, count_d;
  logic                    soc_q, soc_d;
  logic                    jtag_q, jtag_d;
  logic                    btn_prev_q;
  logic                    btn_rise;

  pulpemu_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .ref_clk  (ref_clk),
    .reset    (reset),
    .async_in (pad_reset_btn),
    .level_out(btn_db)
  );

  assign locked_s = lsync2_q;
  assign btn_rise = btn_db & ~btn_prev_q;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    lead_cnt_d = lead_cnt_q;
    count_d    = count_q;
    soc_d      = soc_q;
    jtag_d     = jtag_q;

    if (state_q != S_LOCK_WAIT && !locked_s) begin
      // Lock loss overrides everything once the sequence has left S_LOCK_WAIT.
      state_d    = S_LOCK_WAIT;
      cause_d    = CAUSE_LOCK_LOSS;
      lock_cnt_d = '0;
      hold_cnt_d = '0;
      lead_cnt_d = '0;
      soc_d      = 1'b0;
      jtag_d     = 1'b0;
      if (state_q == S_RUN) count_d = sat_inc(count_q);
    end else begin
      case (state_q)
        S_LOCK_WAIT: begin
          soc_d  = 1'b0;
          jtag_d = 1'b0;
          if (!locked_s) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LOCK_W'(LOCK_STABLE - 1)) begin
            lock_cnt_d = '0;
            hold_cnt_d = '0;
            state_d    = S_HOLD;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end
        S_HOLD: begin
          if (btn_db) begin
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_cnt_d = '0;
            lead_cnt_d = '0;
            jtag_d     = 1'b1;
            state_d    = S_JTAG_REL;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        S_JTAG_REL: begin
          if (lead_cnt_q == LEAD_W'(JTAG_LEAD - 1)) begin
            lead_cnt_d = '0;
            soc_d      = 1'b1;
            state_d    = S_RUN;
          end else begin
            lead_cnt_d = lead_cnt_q + LEAD_W'(1);
          end
        end
        S_RUN: begin
          if (btn_rise || sw_reset_req) begin
            cause_d    = btn_rise ? CAUSE_BUTTON : CAUSE_SW;
            state_d    = S_HOLD;
            hold_cnt_d = '0;
            soc_d      = 1'b0;
            jtag_d     = 1'b0;
            count_d    = sat_inc(count_q);
          end
        end
        default: state_d = S_LOCK_WAIT;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      lsync1_q   <= 1'b0;
      lsync2_q   <= 1'b0;
      state_q    <= S_LOCK_WAIT;
      cause_q    <= CAUSE_POR;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      lead_cnt_q <= '0;
      count_q    <= '0;
      soc_q      <= 1'b0;
      jtag_q     <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      lsync1_q   <= clk_locked;
      lsync2_q   <= lsync1_q;
      state_q    <= state_d;
      cause_q    <= cause_d;
      lock_cnt_q <= lock_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      lead_cnt_q <= lead_cnt_d;
      count_q    <= count_d;
      soc_q      <= soc_d;
      jtag_q     <= jtag_d;
      btn_prev_q <= btn_db;
    end
  end

  assign soc_reset_n = soc_q;
  assign jtag_trst_n = jtag_q;
  assign seq_state   = state_q;
  assign last_cause  = cause_q;
  assign reset_count = count_q;

endmodule

// File: tb/tb_pulpemu_reset_seq.sv
// Directed bench for pulpemu_reset_seq with default parameters.
module tb_pulpemu_reset_seq;

  logic       ref_clk;
  logic       reset;
  logic       pad_reset_btn;
  logic       clk_locked;
  logic       sw_reset_req;
  logic       soc_reset_n;
  logic       jtag_trst_n;
  logic [1:0] seq_state;
  logic [1:0] last_cause;
  logic [7:0] reset_count;

  int pass_cnt = 0;
  int fail_cnt = 0;

  pulpemu_reset_seq dut (
    .ref_clk      (ref_clk),
    .reset        (reset),
    .pad_reset_btn(pad_reset_btn),
    .clk_locked   (clk_locked),
    .sw_reset_req (sw_reset_req),
    .soc_reset_n  (soc_reset_n),
    .jtag_trst_n  (jtag_trst_n),
    .seq_state    (seq_state),
    .last_cause   (last_cause),
    .reset_count  (reset_count)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  task automatic step(input int n);
    repeat (n) @(posedge ref_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // The SoC must never be out of reset while the TAP is still held.
  always @(negedge ref_clk) begin
    if (!reset) begin
      assert (!(soc_reset_n === 1'b1 && jtag_trst_n !== 1'b1))
      else begin
        fail_cnt++;
        $error("FAIL invariant soc_reset_n=%b jtag_trst_n=%b", soc_reset_n, jtag_trst_n);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    pad_reset_btn = 1'b0;
    clk_locked    = 1'b1;
    sw_reset_req  = 1'b0;

    // Power-on
    step(5);
    check("por_state", 32'(seq_state), 0);
    check("por_soc", 32'(soc_reset_n), 0);
    check("por_jtag", 32'(jtag_trst_n), 0);
    check("por_cause", 32'(last_cause), 0);
    check("por_count", 32'(reset_count), 0);
    reset = 1'b0;
    step(41);
    check("por_jtag_41", 32'(jtag_trst_n), 0);
    check("por_state_41", 32'(seq_state), 1);
    step(1);
    check("por_jtag_42", 32'(jtag_trst_n), 1);
    check("por_soc_42", 32'(soc_reset_n), 0);
    check("por_state_42", 32'(seq_state), 2);
    step(3);
    check("por_soc_45", 32'(soc_reset_n), 0);
    step(1);
    check("por_soc_46", 32'(soc_reset_n), 1);
    check("por_state_46", 32'(seq_state), 3);
    check("por_cause_46", 32'(last_cause), 0);
    check("por_count_46", 32'(reset_count), 0);

    // Lock glitch during S_HOLD
    reset = 1'b1;
    step(2);
    check("rst2_state", 32'(seq_state), 0);
    check("rst2_soc", 32'(soc_reset_n), 0);
    reset = 1'b0;
    step(20);
    check("glitch_in_hold", 32'(seq_state), 1);
    clk_locked = 1'b0;
    step(2);
    check("glitch_still_hold", 32'(seq_state), 1);
    step(1);
    clk_locked = 1'b1;
    check("glitch_state", 32'(seq_state), 0);
    check("glitch_cause", 32'(last_cause), 1);
    check("glitch_jtag", 32'(jtag_trst_n), 0);
    step(41);
    check("glitch_jtag_64", 32'(jtag_trst_n), 0);
    step(1);
    check("glitch_jtag_65", 32'(jtag_trst_n), 1);
    check("glitch_state_65", 32'(seq_state), 2);
    step(3);
    check("glitch_soc_68", 32'(soc_reset_n), 0);
    step(1);
    check("glitch_soc_69", 32'(soc_reset_n), 1);
    check("glitch_state_69", 32'(seq_state), 3);
    check("glitch_count", 32'(reset_count), 0);
    check("glitch_cause_69", 32'(last_cause), 1);

    // Button bounce then a sustained press
    for (int s = 0; s < 8; s++) begin
      pad_reset_btn = (s % 2 == 0);
      step(5);
      check("bounce_run", 32'(seq_state), 3);
    end
    check("bounce_soc", 32'(soc_reset_n), 1);
    pad_reset_btn = 1'b1;
    step(18);
    check("press_soc_18", 32'(soc_reset_n), 1);
    check("press_state_18", 32'(seq_state), 3);
    step(1);
    check("press_soc_19", 32'(soc_reset_n), 0);
    check("press_jtag_19", 32'(jtag_trst_n), 0);
    check("press_state_19", 32'(seq_state), 1);
    check("press_count", 32'(reset_count), 1);
    check("press_cause", 32'(last_cause), 2);
    step(11);
    pad_reset_btn = 1'b0;
    step(49);
    check("press_jtag_79", 32'(jtag_trst_n), 0);
    check("press_state_79", 32'(seq_state), 1);
    step(1);
    check("press_jtag_80", 32'(jtag_trst_n), 1);
    check("press_state_80", 32'(seq_state), 2);
    step(3);
    check("press_soc_83", 32'(soc_reset_n), 0);
    step(1);
    check("press_soc_84", 32'(soc_reset_n), 1);
    check("press_count_84", 32'(reset_count), 1);
    check("press_cause_84", 32'(last_cause), 2);

    // Software request, second request during S_HOLD ignored
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    check("sw_soc", 32'(soc_reset_n), 0);
    check("sw_jtag", 32'(jtag_trst_n), 0);
    check("sw_state", 32'(seq_state), 1);
    check("sw_count", 32'(reset_count), 2);
    check("sw_cause", 32'(last_cause), 3);
    step(9);
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    check("sw2_state", 32'(seq_state), 1);
    check("sw2_count", 32'(reset_count), 2);
    step(21);
    check("sw_jtag_32", 32'(jtag_trst_n), 0);
    step(1);
    check("sw_jtag_33", 32'(jtag_trst_n), 1);
    step(3);
    check("sw_soc_36", 32'(soc_reset_n), 0);
    step(1);
    check("sw_soc_37", 32'(soc_reset_n), 1);
    check("sw_state_37", 32'(seq_state), 3);
    check("sw_count_37", 32'(reset_count), 2);

    // Priority: lock loss, button edge and sw request seen on the same edge
    pad_reset_btn = 1'b1;
    step(16);
    clk_locked = 1'b0;
    step(2);
    sw_reset_req = 1'b1;
    check("prio_state_pre", 32'(seq_state), 3);
    check("prio_soc_pre", 32'(soc_reset_n), 1);
    step(1);
    sw_reset_req  = 1'b0;
    pad_reset_btn = 1'b0;
    clk_locked    = 1'b1;
    check("prio_state", 32'(seq_state), 0);
    check("prio_cause", 32'(last_cause), 1);
    check("prio_soc", 32'(soc_reset_n), 0);
    check("prio_jtag", 32'(jtag_trst_n), 0);
    step(53);
    check("prio_soc_72", 32'(soc_reset_n), 0);
    step(1);
    check("prio_soc_73", 32'(soc_reset_n), 1);
    check("prio_state_73", 32'(seq_state), 3);

    // Saturation of reset_count
    for (int i = 0; i < 260; i++) begin
      sw_reset_req = 1'b1;
      step(1);
      sw_reset_req = 1'b0;
      step(36);
      check("sat_back_in_run", 32'(seq_state), 3);
    end
    check("sat_count", 32'(reset_count), 255);
    check("sat_cause", 32'(last_cause), 3);
    check("sat_soc", 32'(soc_reset_n), 1);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
